// File: rtl/fib_ascii_converter_pkg.sv
// Purpose: shared constants, FSM encoding and elaboration helpers for the
//          Fibonacci binary-to-ASCII converter.
// Contents: ASCII_ZERO, ASCII_SPACE, state_e (IDLE/SHIFT/FORMAT/DONE),
//           clog2_f (counter width), min_digits_f (decimal digits needed).
package fib_ascii_converter_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  // ceil(w * log10(2)) with log10(2) approximated as 0.30103.
  function automatic int unsigned min_digits_f(input int unsigned w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/fib_ascii_converter_bcd_adjust_shift.sv
// Purpose: one combinational double-dabble step: add 3 to every BCD nibble
//          that is >= 5, then shift {bcd, bin} left by one bit.
// Ports:   bcd        - current BCD accumulator (NUM_DIGITS nibbles)
//          bin        - remaining binary shift register
//          bcd_next_c - accumulator after adjust and shift
//          bin_next_c - binary register after shift
module fib_ascii_converter_bcd_adjust_shift #(
  parameter int unsigned IN_WIDTH   = 24,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic [4*NUM_DIGITS-1:0] bcd,
  input  logic [IN_WIDTH-1:0]     bin,
  output logic [4*NUM_DIGITS-1:0] bcd_next_c,
  output logic [IN_WIDTH-1:0]     bin_next_c
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;

  logic [BCD_W-1:0] adj;

  // Per-nibble +3 correction so the following shift carries into the next digit.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_next_c = (adj << 1) | {{(BCD_W-1){1'b0}}, bin[IN_WIDTH-1]};
  assign bin_next_c = bin << 1;

endmodule

// File: rtl/fib_ascii_converter.sv
// Purpose: sequential binary-to-ASCII-decimal converter (double-dabble, one
//          bit per cycle) between the Fibonacci generator and the text path.
// Ports:   clk, rst (sync, active-high), enable (clock enable)
//          in_word/in_valid/in_ready   - binary term input handshake
//          out_ascii/out_valid/out_ready - ASCII digits (MS digit in top byte)
// Config:  FIB_ASCII_BLANK_EN - when defined, leading zero digits become
//          spaces (LS digit always numeric).
module fib_ascii_converter
  import fib_ascii_converter_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 24,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [IN_WIDTH-1:0]     in_word,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [8*NUM_DIGITS-1:0] out_ascii,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = clog2_f(IN_WIDTH + 1);

  if (NUM_DIGITS < min_digits_f(IN_WIDTH)) begin : g_digit_check
    $error("NUM_DIGITS too small to hold every IN_WIDTH-bit value");
  end

  state_e                  state;
  logic [BCD_W-1:0]        bcd;
  logic [IN_WIDTH-1:0]     bin;
  logic [CNT_W-1:0]        cnt;
  logic [BCD_W-1:0]        bcd_next_c;
  logic [IN_WIDTH-1:0]     bin_next_c;
  logic [8*NUM_DIGITS-1:0] ascii_c;

  fib_ascii_converter_bcd_adjust_shift #(
    .IN_WIDTH  (IN_WIDTH),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_step (
    .bcd       (bcd),
    .bin       (bin),
    .bcd_next_c(bcd_next_c),
    .bin_next_c(bin_next_c)
  );

  // Ready is dropped immediately while reset is asserted.
  assign in_ready = (state == IDLE) && !rst;

  // BCD digits to ASCII, optionally blanking leading zeros above the LS digit.
  always_comb begin
    logic [3:0] digit;
`ifdef FIB_ASCII_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    ascii_c = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      digit = bcd[4*i +: 4];
      ascii_c[8*i +: 8] = ASCII_ZERO + {4'h0, digit};
`ifdef FIB_ASCII_BLANK_EN
      if (digit != 4'd0) lead = 1'b0;
      if (lead && (i != 0)) ascii_c[8*i +: 8] = ASCII_SPACE;
`endif
    end
  end

  // Control FSM, datapath and output registers; reset ignores enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_ascii <= {NUM_DIGITS{ASCII_ZERO}};
      bcd       <= '0;
      bin       <= '0;
      cnt       <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin   <= in_word;
            bcd   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bcd <= bcd_next_c;
          bin <= bin_next_c;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(IN_WIDTH - 1)) state <= FORMAT;
        end
        FORMAT: begin
          out_ascii <= ascii_c;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_ascii_converter.sv
module tb_fib_ascii_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_ascii;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  fib_ascii_converter #(.IN_WIDTH(24), .NUM_DIGITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .in_word  (in_word),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_ascii(out_ascii),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [23:0] word;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Leading '0' characters above the LS digit become spaces in the blanking build.
  function automatic logic [63:0] fmt(input logic [63:0] s);
    logic [63:0] r;
    r = s;
`ifdef FIB_ASCII_BLANK_EN
    for (int i = 7; i >= 1; i--) begin
      if (r[8*i +: 8] != 8'h30) break;
      r[8*i +: 8] = 8'h20;
    end
`endif
    return r;
  endfunction

  function automatic logic [63:0] to_dec(input longint unsigned v);
    logic [63:0] s;
    longint unsigned x;
    x = v;
    for (int i = 0; i < 8; i++) begin
      s[8*i +: 8] = 8'h30 + 8'(x % 10);
      x = x / 10;
    end
    return fmt(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [23:0] w);
    int n;
    in_word  = w;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_word  = ~w;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin tick(); lat++; end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_valid", 64'(out_valid), 64'd0);
    check("release_ready", 64'(in_ready), 64'd1);
  endtask

  task automatic convert(input string name, input logic [23:0] w, input logic [63:0] exp);
    int lat;
    accept(w);
    wait_valid(lat);
    check({name, "_lat"}, 64'(lat), 64'd25);
    check(name, out_ascii, exp);
    release_out();
  endtask

  initial begin
    vec_t vecs[8];
    logic [63:0] hold;
    int lat;
    longint unsigned fa, fb, ft;

    vecs[0] = '{24'd0,        fmt("00000000")};
    vecs[1] = '{24'd16777215, fmt("16777215")};
    vecs[2] = '{24'd46368,    fmt("00046368")};
    vecs[3] = '{24'd832040,   fmt("00832040")};
    vecs[4] = '{24'd1,        fmt("00000001")};
    vecs[5] = '{24'd9,        fmt("00000009")};
    vecs[6] = '{24'd10000000, fmt("10000000")};
    vecs[7] = '{24'd5555555,  fmt("05555555")};

    rst = 1'b1; enable = 1'b1; in_word = '0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_ascii", out_ascii, "00000000");
    check("rst_in_ready",  64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 8; i++) convert($sformatf("vec%0d", i), vecs[i].word, vecs[i].exp);

    // Fibonacci F0..F35 against the decimal model
    fa = 0; fb = 1;
    for (int i = 0; i <= 35; i++) begin
      convert($sformatf("fib%0d", i), 24'(fa), to_dec(fa));
      ft = fa + fb; fa = fb; fb = ft;
    end

    // Backpressure: output held for 10 cycles with out_ready low
    accept(24'd196418);
    wait_valid(lat);
    check("bp_lat", 64'(lat), 64'd25);
    hold = out_ascii;
    check("bp_value", hold, fmt("00196418"));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_ascii_hold", out_ascii, hold);
      check("bp_valid_hold", 64'(out_valid), 64'd1);
      check("bp_in_ready",   64'(in_ready), 64'd0);
    end
    // enable low blocks the output handshake
    enable = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("en_blocks_out", 64'(out_valid), 64'd1);
    enable = 1'b1;
    tick();
    out_ready = 1'b0;
    check("en_release_valid", 64'(out_valid), 64'd0);
    check("en_release_ready", 64'(in_ready), 64'd1);

    // Reset pulse at shift 12 discards the in-flight word
    accept(24'd832040);
    repeat (12) tick();
    rst = 1'b1;
    #1;
    check("midrst_ready_low", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_valid",  64'(out_valid), 64'd0);
    check("midrst_ascii",  out_ascii, "00000000");
    check("midrst_ready",  64'(in_ready), 64'd1);
    repeat (30) tick();
    check("midrst_no_out", 64'(out_valid), 64'd0);
    convert("after_rst", 24'd121393, fmt("00121393"));

    // Enable low for 5 cycles mid-shift stretches latency by exactly 5
    accept(24'd121393);
    repeat (10) tick();
    enable = 1'b0;
    repeat (5) tick();
    enable = 1'b1;
    wait_valid(lat);
    check("stall_lat", 64'(lat + 15), 64'd30);
    check("stall_ascii", out_ascii, fmt("00121393"));
    release_out();

    // in_word ignored after acceptance; output holds through the next conversion
    accept(24'd46368);
    in_word = 24'd999999;
    repeat (5) tick();
    check("hold_in_shift", out_ascii, fmt("00121393"));
    wait_valid(lat);
    check("sampled_once", out_ascii, fmt("00046368"));
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
